// File: rtl/ikaopll_bus_write_scheduler.sv
// Buffered IKAOPLL/YM2413 CPU-bus write sequencer: FIFO of {addr,data} replayed as timed address/data cycles.
// Optional feature: `IKAOPLL_WRSCHED_SKIPADDR_EN drops the address cycle when it repeats the last address.
module ikaopll_bus_write_scheduler #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned WR_PULSE  = 2,
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84
) (
  input  logic             i_EMUCLK,
  input  logic             i_IC_n,
  input  logic             i_phiM_PCEN_n,
  input  logic             i_PUSH,
  input  logic [7:0]       i_PUSH_ADDR,
  input  logic [7:0]       i_PUSH_DATA,
  input  logic             i_FLUSH,
  output logic             o_PUSH_READY,
  output logic [FIFO_AW:0] o_FIFO_LEVEL,
  output logic             o_BUSY,
  output logic             o_CS_n,
  output logic             o_WR_n,
  output logic             o_A0,
  output logic [7:0]       o_D
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned MAXW1 = (ADDR_WAIT > WR_PULSE) ? ADDR_WAIT : WR_PULSE;
  localparam int unsigned CMAX  = (DATA_WAIT > MAXW1) ? DATA_WAIT : MAXW1;
  localparam int unsigned CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SET, S_A_PULSE, S_A_WAIT, S_D_SET, S_D_PULSE, S_D_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, last_c;
  logic                en_c, done_c, take_c, pop_c, push_ok_c;
  logic [7:0]          wa_q, wa_d, wd_q, wd_d;
  logic                cs_n_q, cs_n_d, a0_q, a0_d, busy_q, ready_q;
  logic [7:0]          d_q, d_d;
  logic [15:0]         mem [DEPTH];
  logic [15:0]         head_c;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
  logic                la_vld_q, la_vld_d;
  logic [7:0]          la_q, la_d;
`endif

  assign en_c      = ~i_phiM_PCEN_n;
  assign head_c    = mem[rd_ptr_q];
  assign push_ok_c = i_PUSH & ready_q & ~i_FLUSH;

  // FIFO pointers and level; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_FLUSH) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      level_d = level_q + LW'(push_ok_c) - LW'(pop_c);
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (push_ok_c) mem[wr_ptr_q] <= {i_PUSH_ADDR, i_PUSH_DATA};
  end

  // Sequencer: next state, phase counter and bus outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    pop_c   = 1'b0;
    take_c  = 1'b0;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
    la_vld_d = la_vld_q;
    la_d     = la_q;
`endif
    case (state_q)
      S_A_PULSE, S_D_PULSE: last_c = CW'(WR_PULSE - 1);
      S_A_WAIT:             last_c = CW'(ADDR_WAIT - 1);
      S_D_WAIT:             last_c = CW'(DATA_WAIT - 1);
      default:              last_c = '0;
    endcase
    done_c = en_c && (cnt_q == last_c);
    if (en_c && (state_q != S_IDLE)) cnt_d = done_c ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE:    take_c = 1'b1;
      S_A_SET:   if (done_c) state_d = S_A_PULSE;
      S_A_PULSE: if (done_c) begin
        state_d = S_A_WAIT;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
        la_vld_d = 1'b1;
        la_d     = wa_q;
`endif
      end
      S_A_WAIT:  if (done_c) state_d = S_D_SET;
      S_D_SET:   if (done_c) state_d = S_D_PULSE;
      S_D_PULSE: if (done_c) state_d = S_D_WAIT;
      S_D_WAIT:  if (done_c) begin
        state_d = S_IDLE;
        take_c  = 1'b1;
      end
      default:   state_d = S_IDLE;
    endcase

    if (take_c && (level_q != '0) && !i_FLUSH) begin
      pop_c   = 1'b1;
      wa_d    = head_c[15:8];
      wd_d    = head_c[7:0];
      state_d = S_A_SET;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
      if (la_vld_q && (head_c[15:8] == la_q)) state_d = S_D_SET;
`endif
    end

    // A0/D only move in the SET states, so they are stable whenever CS_n is low
    cs_n_d = !((state_d == S_A_PULSE) || (state_d == S_D_PULSE));
    a0_d   = a0_q;
    d_d    = d_q;
    if (state_d == S_A_SET) begin
      a0_d = 1'b0;
      d_d  = wa_d;
    end else if (state_d == S_D_SET) begin
      a0_d = 1'b1;
      d_d  = wd_d;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      cs_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
      la_vld_q <= 1'b0;
      la_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cs_n_q   <= cs_n_d;
      a0_q     <= a0_d;
      d_q      <= d_d;
      busy_q   <= (state_d != S_IDLE);
      ready_q  <= (level_d != LW'(DEPTH));
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef IKAOPLL_WRSCHED_SKIPADDR_EN
      la_vld_q <= la_vld_d;
      la_q     <= la_d;
`endif
    end
  end

  assign o_PUSH_READY = ready_q;
  assign o_FIFO_LEVEL = level_q;
  assign o_BUSY       = busy_q;
  assign o_CS_n       = cs_n_q;
  assign o_WR_n       = cs_n_q;
  assign o_A0         = a0_q;
  assign o_D          = d_q;

endmodule

// File: tb/tb_ikaopll_bus_write_scheduler.sv
// Directed self-checking bench for ikaopll_bus_write_scheduler (default parameters).
module tb_ikaopll_bus_write_scheduler;

  localparam int unsigned AW = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pcen_n = 1'b1;
  logic        push   = 1'b0;
  logic        flush  = 1'b0;
  logic [7:0]  paddr  = 8'h00;
  logic [7:0]  pdata  = 8'h00;
  logic        ready, busy, cs_n, wr_n, a0;
  logic [AW:0] level;
  logic [7:0]  d;

  ikaopll_bus_write_scheduler dut (
    .i_EMUCLK      (clk),
    .i_IC_n        (rst_n),
    .i_phiM_PCEN_n (pcen_n),
    .i_PUSH        (push),
    .i_PUSH_ADDR   (paddr),
    .i_PUSH_DATA   (pdata),
    .i_FLUSH       (flush),
    .o_PUSH_READY  (ready),
    .o_FIFO_LEVEL  (level),
    .o_BUSY        (busy),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, en_div = 1, phase = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0, hold_a0 = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic [8:0] ev_q [$];
  int ev_fall [$];
  int ev_rise [$];
  int stab_viol = 0, wr_viol = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, busy_falls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 9'h1FF;
  endfunction

  function automatic int fall_at(input int i);
    if (i < ev_fall.size()) return ev_fall[i];
    return -1000;
  endfunction

  function automatic int rise_at(input int i);
    if (i < ev_rise.size()) return ev_rise[i];
    return -1000;
  endfunction

  // One clock: sample just after the edge, record bus events, set up next enable
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (en_div == 0) pcen_n = 1'b1;
    else begin
      phase  = (phase + 1) % en_div;
      pcen_n = (phase != 0);
    end
    if (wr_n !== cs_n) wr_viol++;
    if (prev_cs && !cs_n) begin
      ev_q.push_back({a0, d});
      ev_fall.push_back(cyc);
      hold_a0 = a0;
      hold_d  = d;
    end else if (!cs_n && ((a0 !== hold_a0) || (d !== hold_d))) stab_viol++;
    if (!prev_cs && cs_n) ev_rise.push_back(cyc);
    if (!prev_busy && busy) busy_rise_cyc = cyc;
    if (prev_busy && !busy) begin
      busy_fall_cyc = cyc;
      busy_falls++;
    end
    prev_cs   = cs_n;
    prev_busy = busy;
  endtask

  task automatic clear_mon();
    ev_q.delete();
    ev_fall.delete();
    ev_rise.delete();
    stab_viol  = 0;
    wr_viol    = 0;
    busy_falls = 0;
  endtask

  task automatic push_one(input logic [7:0] a, input logic [7:0] v);
    push  = 1'b1;
    paddr = a;
    pdata = v;
    tick();
    push  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((busy || (level != '0)) && (n < max)) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < max), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cs_n"},  32'(cs_n),  32'd1);
    check({tag, "_wr_n"},  32'(wr_n),  32'd1);
    check({tag, "_a0"},    32'(a0),    32'd0);
    check({tag, "_d"},     32'(d),     32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    logic [8:0] exp_ev [$];
    int n;
    int dur;

    // Power-on reset
    repeat (3) tick();
    check_reset_outs("por");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write, enable every clock
    en_div = 1;
    tick();
    clear_mon();
    push_one(8'h10, 8'h55);
    wait_idle("t2", 300);
    check("t2_nev",    32'(ev_q.size()), 32'd2);
    check("t2_ev0",    32'(ev_at(0)), 32'({1'b0, 8'h10}));
    check("t2_ev1",    32'(ev_at(1)), 32'({1'b1, 8'h55}));
    check("t2_aw",     32'(rise_at(0) - fall_at(0)), 32'd2);
    check("t2_dw",     32'(rise_at(1) - fall_at(1)), 32'd2);
    check("t2_gap",    32'(fall_at(1) - rise_at(0)), 32'd13);
    check("t2_busy",   32'(busy_fall_cyc - busy_rise_cyc), 32'd102);
    check("t2_stable", 32'(stab_viol), 32'd0);
    check("t2_wr_cs",  32'(wr_viol), 32'd0);

    // Same write, enable 1-in-4 clocks
    en_div = 4;
    repeat (4) tick();
    clear_mon();
    push_one(8'h10, 8'h55);
    wait_idle("t3", 1000);
    dur = busy_fall_cyc - busy_rise_cyc;
    check("t3_nev",    32'(ev_q.size()), 32'd2);
    check("t3_ev0",    32'(ev_at(0)), 32'({1'b0, 8'h10}));
    check("t3_ev1",    32'(ev_at(1)), 32'({1'b1, 8'h55}));
    check("t3_aw",     32'(rise_at(0) - fall_at(0)), 32'd8);
    check("t3_dw",     32'(rise_at(1) - fall_at(1)), 32'd8);
    check("t3_gap",    32'(fall_at(1) - rise_at(0)), 32'd52);
    check("t3_busy",   32'((dur >= 405) && (dur <= 408)), 32'd1);
    check("t3_stable", 32'(stab_viol), 32'd0);

    // Stalled enable mid-pulse: bus frozen, FIFO still accepts
    en_div = 1;
    tick();
    clear_mon();
    push_one(8'h70, 8'h77);
    n = 0;
    while (cs_n && (n < 20)) begin
      tick();
      n++;
    end
    check("stall_reach", 32'(n < 20), 32'd1);
    en_div = 0;
    tick();
    push_one(8'h71, 8'h78);
    repeat (20) tick();
    check("stall_cs_n",  32'(cs_n), 32'd0);
    check("stall_a0d",   32'({a0, d}), 32'({1'b0, 8'h70}));
    check("stall_level", 32'(level), 32'd1);
    check("stall_busy",  32'(busy), 32'd1);
    en_div = 1;
    wait_idle("stall", 500);
    check("stall_nev",   32'(ev_q.size()), 32'd4);
    check("stall_ev3",   32'(ev_at(3)), 32'({1'b1, 8'h78}));

    // Fill the FIFO while busy; 17th push dropped; all emitted back-to-back
    clear_mon();
    push_one(8'h40, 8'h80);
    n = 0;
    while (!busy && (n < 10)) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 17; i++) begin
      push_one(8'(8'h40 + i), 8'(8'h80 + i));
      if (i == 16) begin
        check("t4_level16", 32'(level), 32'd16);
        check("t4_ready0",  32'(ready), 32'd0);
      end
    end
    check("t4_level_full", 32'(level), 32'd16);
    check("t4_ready_full", 32'(ready), 32'd0);
    wait_idle("t4", 2200);
    check("t4_nev", 32'(ev_q.size()), 32'd34);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("t4_addr%0d", k), 32'(ev_at(2 * k)),     32'({1'b0, 8'(8'h40 + k)}));
      check($sformatf("t4_data%0d", k), 32'(ev_at(2 * k + 1)), 32'({1'b1, 8'(8'h80 + k)}));
    end
    check("t4_nogap", 32'(busy_falls), 32'd1);
    check("t4_stable", 32'(stab_viol), 32'd0);

    // Flush (with a simultaneous push) during the first address wait
    clear_mon();
    push_one(8'h20, 8'h11);
    push_one(8'h21, 8'h12);
    push_one(8'h22, 8'h13);
    n = 0;
    while ((ev_rise.size() < 1) && (n < 50)) begin
      tick();
      n++;
    end
    check("t5_reach", 32'(n < 50), 32'd1);
    flush = 1'b1;
    push_one(8'h23, 8'h14);
    flush = 1'b0;
    check("t5_level", 32'(level), 32'd0);
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_busy",  32'(busy),  32'd1);
    wait_idle("t5", 300);
    check("t5_nev", 32'(ev_q.size()), 32'd2);
    check("t5_ev0", 32'(ev_at(0)), 32'({1'b0, 8'h20}));
    check("t5_ev1", 32'(ev_at(1)), 32'({1'b1, 8'h11}));
    repeat (3) tick();
    check("t5_busy_end", 32'(busy), 32'd0);

    // Flush in IDLE on the clock the pop would happen
    clear_mon();
    push_one(8'h24, 8'h14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    check("t5b_busy",  32'(busy), 32'd0);
    check("t5b_level", 32'(level), 32'd0);
    check("t5b_nev",   32'(ev_q.size()), 32'd0);

    // Reset during data pulse
    clear_mon();
    push_one(8'h60, 8'h66);
    n = 0;
    while (!(!cs_n && a0) && (n < 200)) begin
      tick();
      n++;
    end
    check("t1_reach", 32'(n < 200), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("t1");
    rst_n = 1'b1;
    repeat (2) tick();

    // Repeated address (address cycle dropped only with the skip feature)
    clear_mon();
    push_one(8'h30, 8'h01);
    push_one(8'h30, 8'h02);
    push_one(8'h31, 8'h03);
    wait_idle("t6", 800);
    exp_ev.push_back({1'b0, 8'h30});
    exp_ev.push_back({1'b1, 8'h01});
`ifndef IKAOPLL_WRSCHED_SKIPADDR_EN
    exp_ev.push_back({1'b0, 8'h30});
`endif
    exp_ev.push_back({1'b1, 8'h02});
    exp_ev.push_back({1'b0, 8'h31});
    exp_ev.push_back({1'b1, 8'h03});
    check("t6_nev", 32'(ev_q.size()), 32'(exp_ev.size()));
    for (int k = 0; k < exp_ev.size(); k++)
      check($sformatf("t6_ev%0d", k), 32'(ev_at(k)), 32'(exp_ev[k]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
